joybus_poll_sched: RTL and testbench
====================================

Name: joybus_poll_sched

Overview:
Sequencer that owns the JOYBUS host transceiver and decides what it sends and when. After reset it probes for a controller with the info command (0x00). While a controller answers, it issues the poll command (0x01) every POLL_PERIOD cycles and publishes the 32-bit button/stick word. It handles response timeouts, retries and controller loss, and sits between the transceiver and the button-decode/game logic.

Parameters:
POLL_PERIOD, 416667, cycles between poll starts (~60 Hz at 25 MHz)
RSP_TIMEOUT, 2500, cycles allowed from host_tx_done to host_rx_done (100 us)
MAX_RETRY, 3, consecutive failed transactions before declaring controller absent
PROBE_BACKOFF, 25000, idle cycles between probes while absent

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
host_start  out  1  one-cycle pulse: transceiver begins a transaction
host_cmd  out  8  command byte; valid and held stable from host_start until host_rx_done or timeout
host_rsp_bytes  out  3  expected response length: 3 for info, 4 for poll
host_tx_done  in  1  one-cycle pulse: command and stop bit fully sent
host_rx_done  in  1  one-cycle pulse: response complete
host_rx_data  in  32  response, left-aligned, MSB = first bit received; valid on host_rx_done
host_rx_err  in  1  qualifies host_rx_done: framing/length error
cntlr_present  out  1  controller answering
pad_state  out  32  last good poll response (bit31=A, bit30=B, bit29=Z, ...)
pad_valid  out  1  one-cycle pulse when pad_state updates
fail_cnt  out  2  consecutive failures in the current streak

Behaviour:
- Reset values: host_start=0, host_cmd=0x00, host_rsp_bytes=3, cntlr_present=0, pad_state=0, pad_valid=0, fail_cnt=0. The FSM resets to PROBE_ISSUE, and all counters clear.
- PROBE_ISSUE: pulse host_start with host_cmd=0x00, host_rsp_bytes=3, then go to WAIT_TX.
- POLL_ISSUE: pulse host_start with host_cmd=0x01, host_rsp_bytes=4, then go to WAIT_TX. The period counter restarts on this same cycle.
- WAIT_TX: wait for host_tx_done. It has no timeout; the transceiver always completes TX. Then clear the timeout counter and go to WAIT_RX.
- WAIT_RX: the timeout counter increments every cycle.
  - host_rx_done with host_rx_err=0 is a success.
  - host_rx_done with host_rx_err=1 is a failure.
  - Timeout counter reaching RSP_TIMEOUT-1 without host_rx_done is a failure.
  - If host_rx_done and the timeout terminal count occur on the same cycle, rx_done wins.
  - host_rx_done seen in any state other than WAIT_RX is ignored.
- Success on probe: cntlr_present<=1, fail_cnt<=0, go to POLL_WAIT. The first poll is issued immediately, not after a full period.
- Success on poll: pad_state<=host_rx_data, pad_valid pulses on the cycle after host_rx_done, fail_cnt<=0, go to POLL_WAIT.
- Failure handling:
  - On any failure, fail_cnt increments.
  - If the increment reaches MAX_RETRY: cntlr_present<=0, fail_cnt<=0, pad_state<=0 (no pad_valid pulse), go to BACKOFF.
  - Otherwise retry the same command immediately: PROBE_ISSUE or POLL_ISSUE.
- POLL_WAIT: go to POLL_ISSUE when the period counter reaches POLL_PERIOD-1. If the previous transaction took longer than POLL_PERIOD, issue on the next cycle; a poll is never skipped twice.
- BACKOFF: wait PROBE_BACKOFF cycles, then go to PROBE_ISSUE.
- Only one transaction is ever outstanding. host_start is never asserted outside the *_ISSUE states.
- Counter widths are $clog2(param); counters saturate and never wrap.
- Asynchronous rst mid-transaction returns the FSM to PROBE_ISSUE. The transceiver is reset by the same rst.

Optional Feature:
Macro POLL_STATS_EN.
- Defined: adds outputs poll_total (16-bit, increments on each successful poll, wraps) and timeout_total (16-bit, increments on each timeout failure, saturates at 0xFFFF). Both reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
Bench uses POLL_PERIOD=200, RSP_TIMEOUT=50, MAX_RETRY=3, PROBE_BACKOFF=100.
- Reset release, model answers info -> host_cmd=0x00 first, cntlr_present=1 after rx_done, POLL_ISSUE with host_cmd=0x01 within 2 cycles.
- Poll response 0xA5C3_1E07 -> pad_state=0xA5C31E07, single pad_valid pulse, bit31=1 (A).
- Steady polling -> consecutive host_start pulses exactly 200 cycles apart.
- Model silent for 1 poll then answers 0x8000_0000 -> host_start repeated 0x01 after 50-cycle timeout, fail_cnt 1 then 0, pad_state=0x80000000.
- Model silent 3 times -> cntlr_present falls, pad_state=0, next host_cmd=0x00 at least 100 cycles later.
- host_rx_err=1 on two polls then good response -> fail_cnt 1, 2, 0; cntlr_present stays 1. rst asserted in WAIT_RX -> all outputs at reset values immediately.

Source files
------------

// File: rtl/joybus_poll_sched.sv
// rtl/joybus_poll_sched.sv - JOYBUS probe/poll sequencer with retry, timeout and backoff.
// Optional macro POLL_STATS_EN adds the poll_total and timeout_total counters.
module joybus_poll_sched #(
  parameter int POLL_PERIOD   = 416667,
  parameter int RSP_TIMEOUT   = 2500,
  parameter int MAX_RETRY     = 3,
  parameter int PROBE_BACKOFF = 25000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        host_start,
  output logic [7:0]  host_cmd,
  output logic [2:0]  host_rsp_bytes,
  input  logic        host_tx_done,
  input  logic        host_rx_done,
  input  logic [31:0] host_rx_data,
  input  logic        host_rx_err,
  output logic        cntlr_present,
  output logic [31:0] pad_state,
  output logic        pad_valid,
  output logic [1:0]  fail_cnt
`ifdef POLL_STATS_EN
  ,
  output logic [15:0] poll_total,
  output logic [15:0] timeout_total
`endif
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(RSP_TIMEOUT);
  localparam int BW = $clog2(PROBE_BACKOFF);
  localparam logic [PW-1:0] PER_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RSP_TIMEOUT - 1);
  localparam logic [BW-1:0] BO_LAST  = BW'(PROBE_BACKOFF - 1);

  typedef enum logic [2:0] {
    PROBE_ISSUE,
    POLL_ISSUE,
    WAIT_TX,
    WAIT_RX,
    POLL_WAIT,
    BACKOFF
  } state_t;

  state_t        state;
  logic          is_poll;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [BW-1:0] backoff_cnt;

  logic       rx_ok;
  logic       tmo_hit;
  logic       txn_fail;
  logic [2:0] fail_next;

  assign rx_ok     = (state == WAIT_RX) && host_rx_done && !host_rx_err;
  assign tmo_hit   = (state == WAIT_RX) && !host_rx_done && (tmo_cnt == TMO_LAST);
  assign txn_fail  = ((state == WAIT_RX) && host_rx_done && host_rx_err) || tmo_hit;
  assign fail_next = {1'b0, fail_cnt} + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= PROBE_ISSUE;
      is_poll        <= 1'b0;
      period_cnt     <= '0;
      tmo_cnt        <= '0;
      backoff_cnt    <= '0;
      host_start     <= 1'b0;
      host_cmd       <= 8'h00;
      host_rsp_bytes <= 3'd3;
      cntlr_present  <= 1'b0;
      pad_state      <= 32'h0;
      pad_valid      <= 1'b0;
      fail_cnt       <= 2'd0;
    end else begin
      host_start <= 1'b0;
      pad_valid  <= 1'b0;
      if (period_cnt != PER_LAST) period_cnt <= period_cnt + PW'(1);

      case (state)
        PROBE_ISSUE: begin
          host_start     <= 1'b1;
          host_cmd       <= 8'h00;
          host_rsp_bytes <= 3'd3;
          is_poll        <= 1'b0;
          state          <= WAIT_TX;
        end
        POLL_ISSUE: begin
          host_start     <= 1'b1;
          host_cmd       <= 8'h01;
          host_rsp_bytes <= 3'd4;
          is_poll        <= 1'b1;
          // The issue cycle itself counts as cycle 0, so the next value is 1.
          period_cnt     <= PW'(1);
          state          <= WAIT_TX;
        end
        WAIT_TX: begin
          if (host_tx_done) begin
            tmo_cnt <= '0;
            state   <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + TW'(1);
          if (rx_ok) begin
            fail_cnt <= 2'd0;
            state    <= POLL_WAIT;
            if (is_poll) begin
              pad_state <= host_rx_data;
              pad_valid <= 1'b1;
            end else begin
              cntlr_present <= 1'b1;
              // Pre-expire the period so the first poll follows right away.
              period_cnt    <= PER_LAST;
            end
          end else if (txn_fail) begin
            if (fail_next >= 3'(MAX_RETRY)) begin
              cntlr_present <= 1'b0;
              fail_cnt      <= 2'd0;
              pad_state     <= 32'h0;
              backoff_cnt   <= '0;
              state         <= BACKOFF;
            end else begin
              fail_cnt <= fail_next[1:0];
              state    <= is_poll ? POLL_ISSUE : PROBE_ISSUE;
            end
          end
        end
        POLL_WAIT: begin
          if (period_cnt == PER_LAST) state <= POLL_ISSUE;
        end
        BACKOFF: begin
          if (backoff_cnt == BO_LAST) state <= PROBE_ISSUE;
          else backoff_cnt <= backoff_cnt + BW'(1);
        end
        default: state <= PROBE_ISSUE;
      endcase
    end
  end

`ifdef POLL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_total    <= 16'h0;
      timeout_total <= 16'h0;
    end else begin
      if (rx_ok && is_poll) poll_total <= poll_total + 16'd1;
      if (tmo_hit && (timeout_total != 16'hFFFF)) timeout_total <= timeout_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_joybus_poll_sched.sv
// tb/tb_joybus_poll_sched.sv - bench for joybus_poll_sched with a scripted transceiver.
module tb_joybus_poll_sched;
  localparam int POLL_PERIOD   = 200;
  localparam int RSP_TIMEOUT   = 50;
  localparam int MAX_RETRY     = 3;
  localparam int PROBE_BACKOFF = 100;
  localparam int K_GOOD = 0, K_ERR = 1, K_SIL = 2;
  localparam int NTBL = 13, NRND = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_start;
  logic [7:0]  host_cmd;
  logic [2:0]  host_rsp_bytes;
  logic        host_tx_done = 1'b0;
  logic        host_rx_done = 1'b0;
  logic [31:0] host_rx_data = 32'h0;
  logic        host_rx_err  = 1'b0;
  logic        cntlr_present;
  logic [31:0] pad_state;
  logic        pad_valid;
  logic [1:0]  fail_cnt;
`ifdef POLL_STATS_EN
  logic [15:0] poll_total;
  logic [15:0] timeout_total;
`endif

  joybus_poll_sched #(
    .POLL_PERIOD(POLL_PERIOD), .RSP_TIMEOUT(RSP_TIMEOUT),
    .MAX_RETRY(MAX_RETRY), .PROBE_BACKOFF(PROBE_BACKOFF)
  ) dut (
    .clk(clk), .rst(rst),
    .host_start(host_start), .host_cmd(host_cmd), .host_rsp_bytes(host_rsp_bytes),
    .host_tx_done(host_tx_done), .host_rx_done(host_rx_done),
    .host_rx_data(host_rx_data), .host_rx_err(host_rx_err),
    .cntlr_present(cntlr_present), .pad_state(pad_state),
    .pad_valid(pad_valid), .fail_cnt(fail_cnt)
`ifdef POLL_STATS_EN
    , .poll_total(poll_total), .timeout_total(timeout_total)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          dly;
    logic [7:0]  cmd;
    logic [1:0]  fail;
    logic        present;
    logic [31:0] pad;
    logic        valid;
  } vec_t;

  vec_t tbl[NTBL];

  // Reference model: controller presence, failure streak and last good pad word.
  int          m_present;
  int          m_fail;
  logic [31:0] m_pad;

  // Scheduling expectation left behind by the previous transaction.
  int prev_cls = 0;
  int prev_start = 0;
  int prev_end = 0;
  logic [1:0] prev_fail = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic model_txn(input int kind, input logic [31:0] data, input int dly, output vec_t v);
    v.kind  = kind;
    v.data  = data;
    v.dly   = dly;
    v.cmd   = (m_present != 0) ? 8'h01 : 8'h00;
    v.valid = 1'b0;
    if (kind == K_GOOD) begin
      if (m_present != 0) begin
        m_pad   = data;
        v.valid = 1'b1;
      end else begin
        m_present = 1;
      end
      m_fail = 0;
    end else begin
      m_fail++;
      if (m_fail == MAX_RETRY) begin
        m_present = 0;
        m_fail    = 0;
        m_pad     = 32'h0;
      end
    end
    v.fail    = 2'(m_fail);
    v.present = (m_present != 0);
    v.pad     = m_pad;
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    int t_start;
    n = 0;
    while (host_start !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (host_start !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL start_wait: no host_start within %0d cycles", n);
      return;
    end
    t_start = cyc;
    case (prev_cls)
      1: chk_rng("poll_spacing", t_start - prev_start, POLL_PERIOD, POLL_PERIOD);
      2: chk_rng("first_poll_delay", t_start - prev_end, 1, 2);
      3: chk_rng("retry_delay", t_start - prev_end, 1, 2);
      4: chk_rng("backoff_gap", t_start - prev_end, PROBE_BACKOFF, PROBE_BACKOFF + 3);
      default: ;
    endcase
    chk("host_cmd", host_cmd, v.cmd);
    chk("rsp_bytes", host_rsp_bytes, (v.cmd == 8'h01) ? 3'd4 : 3'd3);
    @(negedge clk);
    chk("start_one_shot", host_start, 1'b0);
    @(negedge clk);
    host_tx_done = 1'b1;
    @(negedge clk);
    host_tx_done = 1'b0;
    if (v.kind == K_SIL) begin
      repeat (RSP_TIMEOUT - 1) @(negedge clk);
      chk("fail_before_timeout", fail_cnt, prev_fail);
      @(negedge clk);
    end else begin
      repeat (v.dly) @(negedge clk);
      host_rx_done = 1'b1;
      host_rx_data = v.data;
      host_rx_err  = (v.kind == K_ERR);
      @(negedge clk);
      host_rx_done = 1'b0;
      host_rx_err  = 1'b0;
    end
    prev_end = cyc;
    chk("fail_cnt", fail_cnt, v.fail);
    chk("cntlr_present", cntlr_present, v.present);
    chk("pad_state", pad_state, v.pad);
    chk("pad_valid", pad_valid, v.valid);
    chk("cmd_held", host_cmd, v.cmd);
    if (v.valid) begin
      @(negedge clk);
      chk("pad_valid_one_shot", pad_valid, 1'b0);
    end
    if (v.kind == K_GOOD) prev_cls = (v.cmd == 8'h01) ? 1 : 2;
    else prev_cls = (v.fail == 2'd0) ? 4 : 3;
    prev_start = t_start;
    prev_fail  = v.fail;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_host_start"}, host_start, 1'b0);
    chk({tag, "_host_cmd"}, host_cmd, 8'h00);
    chk({tag, "_rsp_bytes"}, host_rsp_bytes, 3'd3);
    chk({tag, "_present"}, cntlr_present, 1'b0);
    chk({tag, "_pad_state"}, pad_state, 32'h0);
    chk({tag, "_pad_valid"}, pad_valid, 1'b0);
    chk({tag, "_fail_cnt"}, fail_cnt, 2'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    int   r;

    //         kind    data          dly cmd    fail  pres  pad           valid
    tbl[0]  = '{K_GOOD, 32'h0500_0200, 5,  8'h00, 2'd0, 1'b1, 32'h0,        1'b0};
    tbl[1]  = '{K_GOOD, 32'hA5C3_1E07, 10, 8'h01, 2'd0, 1'b1, 32'hA5C3_1E07, 1'b1};
    tbl[2]  = '{K_GOOD, 32'h1234_5678, 3,  8'h01, 2'd0, 1'b1, 32'h1234_5678, 1'b1};
    tbl[3]  = '{K_SIL,  32'h0,         0,  8'h01, 2'd1, 1'b1, 32'h1234_5678, 1'b0};
    tbl[4]  = '{K_GOOD, 32'h8000_0000, 49, 8'h01, 2'd0, 1'b1, 32'h8000_0000, 1'b1};
    tbl[5]  = '{K_ERR,  32'hDEAD_0001, 7,  8'h01, 2'd1, 1'b1, 32'h8000_0000, 1'b0};
    tbl[6]  = '{K_ERR,  32'hDEAD_0002, 12, 8'h01, 2'd2, 1'b1, 32'h8000_0000, 1'b0};
    tbl[7]  = '{K_GOOD, 32'h0F0F_0F0F, 0,  8'h01, 2'd0, 1'b1, 32'h0F0F_0F0F, 1'b1};
    tbl[8]  = '{K_SIL,  32'h0,         0,  8'h01, 2'd1, 1'b1, 32'h0F0F_0F0F, 1'b0};
    tbl[9]  = '{K_SIL,  32'h0,         0,  8'h01, 2'd2, 1'b1, 32'h0F0F_0F0F, 1'b0};
    tbl[10] = '{K_SIL,  32'h0,         0,  8'h01, 2'd0, 1'b0, 32'h0,        1'b0};
    tbl[11] = '{K_GOOD, 32'h0500_0200, 20, 8'h00, 2'd0, 1'b1, 32'h0,        1'b0};
    tbl[12] = '{K_GOOD, 32'hFFFF_FFFF, 30, 8'h01, 2'd0, 1'b1, 32'hFFFF_FFFF, 1'b1};

    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst = 1'b0;

    for (int i = 0; i < NTBL; i++) run_txn(tbl[i]);

    // A stray response between polls must not touch the pad word.
    repeat (20) @(negedge clk);
    host_rx_done = 1'b1;
    host_rx_data = 32'hDEAD_BEEF;
    @(negedge clk);
    host_rx_done = 1'b0;
    chk("stray_rx_valid", pad_valid, 1'b0);
    chk("stray_rx_pad", pad_state, 32'hFFFF_FFFF);

    m_present = 1;
    m_fail    = 0;
    m_pad     = 32'hFFFF_FFFF;
    for (int i = 0; i < NRND; i++) begin
      r = $urandom_range(0, 9);
      model_txn((r < 6) ? K_GOOD : (r < 8) ? K_ERR : K_SIL, $urandom,
                $urandom_range(0, RSP_TIMEOUT - 1), v);
      run_txn(v);
    end

    // Asynchronous reset while a response is outstanding.
    n = 0;
    while (host_start !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rst_seq_start", host_start, 1'b1);
    @(negedge clk);
    host_tx_done = 1'b1;
    @(negedge clk);
    host_tx_done = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b0;
    prev_cls  = 0;
    prev_fail = 2'd0;
    m_present = 0;
    m_fail    = 0;
    m_pad     = 32'h0;
    model_txn(K_GOOD, 32'h0500_0200, 4, v);
    run_txn(v);
    model_txn(K_GOOD, 32'h4000_0001, 8, v);
    run_txn(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
